// File: rtl/cache_pkg.sv
// Definitions shared by the cache refill controller and the data cache:
// refill FSM states, word size, and the line-offset width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam int WORD_BYTES = 4;

  function automatic int line_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/refill_addr_gen.sv
// Line base, start offset and word counter producing the word-aligned refill address.
// CRITICAL_WORD_FIRST_EN: start at the missing word's offset and wrap around the line.
module refill_addr_gen
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int OFF_W    = line_off_w(WORDS_PER_LINE);
  localparam int WB_W     = $clog2(WORD_BYTES);
  localparam int LINE_LSB = OFF_W + WB_W;

  logic [ADDR_W-LINE_LSB-1:0] r_base;
  logic [OFF_W-1:0]           r_cnt;
  logic [OFF_W-1:0]           w_start_off;
  logic [OFF_W-1:0]           w_off;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] r_start_off;
  logic [WB_W-1:0]  w_unused_lsb;

  assign w_unused_lsb = i_miss_addr[WB_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_start_off <= '0;
    else if (i_start) r_start_off <= i_miss_addr[LINE_LSB-1:WB_W];
  end

  assign w_start_off = r_start_off;
`else
  logic [LINE_LSB-1:0] w_unused_lsb;

  assign w_unused_lsb = i_miss_addr[LINE_LSB-1:0];
  assign w_start_off  = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_base <= i_miss_addr[ADDR_W-1:LINE_LSB];
      r_cnt  <= '0;
    end else if (i_adv) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // OFF_W-bit sum wraps naturally, keeping every address inside the line
  assign w_off  = w_start_off + r_cnt;
  assign o_addr = {r_base, w_off, {WB_W{1'b0}}};
  assign o_last = (r_cnt == OFF_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: one word request at a time to memory, one write
// strobe per returned word, refill_done pulse when the line is complete.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_refill_we,
  output logic [ADDR_W-1:0] o_refill_addr,
  output logic [31:0]       o_refill_data,
  output logic              o_refill_done,
  output logic              o_busy
);

  refill_state_e r_state, w_state_nxt;

  logic              w_start, w_adv, w_last;
  logic              w_mem_req, w_we, w_done;
  logic [ADDR_W-1:0] w_line_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_mem_req   = 1'b0;
    w_we        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_miss_req) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_mem_req   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mem_ack) begin
          w_we = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  refill_addr_gen #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .ADDR_W        (ADDR_W)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_adv      (w_adv),
    .i_miss_addr(i_miss_addr),
    .o_addr     (w_line_addr),
    .o_last     (w_last)
  );

  // Address/data buses read as zero whenever their strobe is low
  assign o_mem_req     = w_mem_req;
  assign o_mem_addr    = w_mem_req ? w_line_addr : '0;
  assign o_refill_we   = w_we;
  assign o_refill_addr = w_we ? w_line_addr : '0;
  assign o_refill_data = w_we ? i_mem_rdata : '0;
  assign o_refill_done = w_done;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: transaction-level line model plus
// directed scenarios with literal expectations (honours CRITICAL_WORD_FIRST_EN).
module tb_cache_refill_ctrl;

  localparam int W  = 4;
  localparam int AW = 32;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, miss_req, mem_ack;
  logic [AW-1:0] miss_addr;
  logic [31:0]   mem_rdata;
  logic          o_mem_req, o_refill_we, o_refill_done, o_busy;
  logic [AW-1:0] o_mem_addr, o_refill_addr;
  logic [31:0]   o_refill_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // line model state
  bit          m_live = 0, m_busy = 0, m_req_now = 0, m_outst = 0, m_done_now = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_out_addr;
  int          acc_cyc_q[$], done_cyc_q[$];
  logic [31:0] obs_addr[$], obs_data[$];
  int          we_cnt = 0, done_cnt = 0, req_cnt = 0;

  // memory responder control
  bit resp_en  = 0;
  int resp_dly = 0;
  int resp_n   = 0;

  logic [31:0] expA[4], expB[4];

  always #5 clk = ~clk;

  cache_refill_ctrl #(.WORDS_PER_LINE(W), .ADDR_W(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_miss_req   (miss_req),
    .i_miss_addr  (miss_addr),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_refill_we  (o_refill_we),
    .o_refill_addr(o_refill_addr),
    .o_refill_data(o_refill_data),
    .o_refill_done(o_refill_done),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Word addresses of a line, in request order, straight from the address rules
  function automatic void build_line(input logic [31:0] a);
    logic [31:0] base;
    int          st;
    base = a & ~32'(W * 4 - 1);
    st   = CWF ? int'((a >> 2) % W) : 0;
    for (int k = 0; k < W; k++) m_q.push_back(base + 32'(4 * ((st + k) % W)));
  endfunction

  // Compare process: checks every output each cycle, then advances the model
  initial begin
    bit          exp_we;
    logic [31:0] exp_maddr;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_live) begin
        exp_we    = m_outst && (mem_ack === 1'b1);
        exp_maddr = '0;
        if (m_req_now && m_q.size() > 0) exp_maddr = m_q[0];
        chk("mem_req",     32'(o_mem_req),     32'(m_req_now));
        chk("mem_addr",    o_mem_addr,         exp_maddr);
        chk("refill_we",   32'(o_refill_we),   32'(exp_we));
        chk("refill_addr", o_refill_addr,      exp_we ? m_out_addr : 32'h0);
        chk("refill_data", o_refill_data,      exp_we ? mem_rdata : 32'h0);
        chk("refill_done", 32'(o_refill_done), 32'(m_done_now));
        chk("busy",        32'(o_busy),        32'(m_busy));
        if (o_mem_req)     begin obs_addr.push_back(o_mem_addr);    req_cnt++; end
        if (o_refill_we)   begin obs_data.push_back(o_refill_data); we_cnt++;  end
        if (o_refill_done) begin done_cyc_q.push_back(cyc);         done_cnt++; end
      end
      if (rst) begin
        m_live = 1; m_busy = 0; m_req_now = 0; m_outst = 0; m_done_now = 0;
        m_q.delete();
      end else if (m_done_now) begin
        m_done_now = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (miss_req) begin
          m_busy = 1; m_req_now = 1;
          build_line(miss_addr);
          acc_cyc_q.push_back(cyc);
        end
      end else if (m_req_now) begin
        m_req_now = 0; m_outst = 1;
        m_out_addr = m_q.pop_front();
      end else if (m_outst && mem_ack) begin
        m_outst = 0;
        if (m_q.size() == 0) m_done_now = 1;
        else                 m_req_now = 1;
      end
    end
  end

  // Memory: acks each request after resp_dly extra cycles with data 0xA0 + n
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && o_mem_req) begin
        @(posedge clk);
        repeat (resp_dly) @(posedge clk);
        #1 mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(resp_n); resp_n++;
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (o_refill_done === 1'b1) seen = 1;
    end
    chk({nm, " refill_done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_req(input int max, input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (o_mem_req === 1'b1) seen = 1;
    end
    chk({nm, " mem_req seen"}, 32'(seen), 32'd1);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete();
    acc_cyc_q.delete(); done_cyc_q.delete();
  endtask

  initial begin
    int we0, done0;
    if (CWF) begin
      expA = '{32'h104, 32'h108, 32'h10C, 32'h100};
      expB = '{32'h10C, 32'h100, 32'h104, 32'h108};
    end else begin
      expA = '{32'h100, 32'h104, 32'h108, 32'h10C};
      expB = '{32'h100, 32'h104, 32'h108, 32'h10C};
    end
    rst = 1; miss_req = 0; miss_addr = '0; mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
    repeat (3) step();
    chk("reset busy",        32'(o_busy),        32'd0);
    chk("reset mem_req",     32'(o_mem_req),     32'd0);
    chk("reset mem_addr",    o_mem_addr,         32'd0);
    chk("reset refill_we",   32'(o_refill_we),   32'd0);
    chk("reset refill_addr", o_refill_addr,      32'd0);
    chk("reset refill_data", o_refill_data,      32'd0);
    chk("reset refill_done", 32'(o_refill_done), 32'd0);
    rst = 0;
    step();

    // A: zero-wait line refill at 0x104
    clear_obs(); resp_en = 1; resp_dly = 0; resp_n = 0;
    miss_addr = 32'h104; miss_req = 1;
    wait_done(40, "A");
    step(); miss_req = 0; step();
    chk("A request count", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4 && obs_data.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("A mem_addr[%0d]", k), obs_addr[k], expA[k]);
        chk($sformatf("A refill_data[%0d]", k), obs_data[k], 32'hA0 + 32'(k));
      end
    if (acc_cyc_q.size() == 1 && done_cyc_q.size() == 1)
      chk("A latency", 32'(done_cyc_q[0] - acc_cyc_q[0]), 32'd9);

    // B: memory answers 3 cycles late, miss on the last word of the line
    clear_obs(); resp_dly = 3; resp_n = 0; req_cnt = 0;
    miss_addr = 32'h10C; miss_req = 1;
    wait_done(80, "B");
    step(); miss_req = 0; step();
    chk("B mem_req cycles", 32'(req_cnt), 32'd4);
    if (obs_addr.size() == 4 && obs_data.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("B mem_addr[%0d]", k), obs_addr[k], expB[k]);
        chk($sformatf("B refill_data[%0d]", k), obs_data[k], 32'hA0 + 32'(k));
      end
    if (acc_cyc_q.size() == 1 && done_cyc_q.size() == 1)
      chk("B latency", 32'(done_cyc_q[0] - acc_cyc_q[0]), 32'd21);

    // C: miss_req held through DONE, address changed mid-refill to 0x1F0
    clear_obs(); resp_dly = 0; resp_n = 0;
    miss_addr = 32'h104; miss_req = 1;
    step(); step();
    miss_addr = 32'h1F0;
    wait_done(40, "C1");
    wait_done(40, "C2");
    step(); miss_req = 0; step();
    chk("C accept count", 32'(acc_cyc_q.size()), 32'd2);
    chk("C request count", 32'(obs_addr.size()), 32'd8);
    if (acc_cyc_q.size() == 2 && done_cyc_q.size() == 2)
      chk("C back-to-back start", 32'(acc_cyc_q[1]), 32'(done_cyc_q[0] + 1));
    if (obs_addr.size() == 8)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("C first mem_addr[%0d]", k), obs_addr[k], expA[k]);
        chk($sformatf("C second mem_addr[%0d]", k), obs_addr[4 + k], 32'h1F0 + 32'(4 * k));
      end

    // D: reset after the 2nd ack abandons the line; a stray ack is ignored
    clear_obs(); resp_en = 0; we0 = we_cnt; done0 = done_cnt;
    miss_addr = 32'h104; miss_req = 1;
    wait_req(10, "D1");
    step(); miss_req = 0; mem_ack = 1; mem_rdata = 32'h55;
    step(); mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
    wait_req(10, "D2");
    step(); mem_ack = 1; mem_rdata = 32'h66;
    step(); mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
    rst = 1;
    step(); rst = 0;
    chk("D busy after rst",     32'(o_busy),      32'd0);
    chk("D mem_req after rst",  32'(o_mem_req),   32'd0);
    chk("D mem_addr after rst", o_mem_addr,       32'd0);
    mem_ack = 1; mem_rdata = 32'h77;
    step(); mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
    step(); step();
    chk("D write strobes", 32'(we_cnt - we0), 32'd2);
    chk("D no refill_done", 32'(done_cnt - done0), 32'd0);
    if (obs_data.size() == 2) begin
      chk("D refill_data[0]", obs_data[0], 32'h55);
      chk("D refill_data[1]", obs_data[1], 32'h66);
    end

    // E: ack pulsed while idle
    we0 = we_cnt;
    mem_ack = 1; mem_rdata = 32'h99;
    repeat (3) step();
    mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("E busy idle", 32'(o_busy), 32'd0);
    chk("E no strobe", 32'(we_cnt - we0), 32'd0);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
